jump_key_conditioner: RTL and testbench

JUMP_KEY_CONDITIONER -- requirements
Module: jump_key_conditioner

---
 rtl/jump_key_conditioner_pkg.sv | 14 +
 rtl/jump_key_conditioner_key_sync.sv | 21 ++
 rtl/jump_key_conditioner.sv | 126 ++++++++++++
 tb/tb_jump_key_conditioner.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/jump_key_conditioner_pkg.sv
// Shared definitions for the jump key conditioner: debounce FSM encoding and defaults.
package jump_key_conditioner_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 2400;
  localparam int unsigned PRESS_CNT_W             = 8;

  typedef enum logic [1:0] {
    ST_UP           = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_DOWN         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

endpackage

// File: rtl/jump_key_conditioner_key_sync.sv
// Two-flop synchronizer for the raw push-button level.
module key_sync (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta <= 1'b0;
      q_o  <= 1'b0;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/jump_key_conditioner.sv
// Debounces the jump push-button and turns accepted presses into a jump request
// that is held until the next game-tick rising edge consumes it.
module jump_key_conditioner
  import jump_key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit          KEY_ACTIVE_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_i,
  input  logic       tick_i,
  output logic       jmp_o,
  output logic       press_o,
  output logic       key_level_o,
  output logic [7:0] press_cnt_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  key_state_e       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             key_s;
  logic             k;
  logic             tick_q;
  logic             tick_rise_c;
  logic             press_set_c;
  logic             level_next_c;

  key_sync u_key_sync (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (key_i),
    .q_o  (key_s)
  );

  assign k = KEY_ACTIVE_HIGH ? key_s : ~key_s;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_UP;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state: a level change must persist DEBOUNCE_CYCLES cycles to be accepted
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      ST_UP: begin
        if (k) begin
          state_next = ST_PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!k) begin
          state_next = ST_UP;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_DOWN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_DOWN: begin
        if (!k) begin
          state_next = ST_RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (k) begin
          state_next = ST_DOWN;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_UP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_UP;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode, registered below
  always_comb begin
    press_set_c  = 1'b0;
    level_next_c = 1'b0;
    press_set_c  = (state == ST_PRESS_WAIT) && (state_next == ST_DOWN);
    level_next_c = (state_next == ST_DOWN) || (state_next == ST_RELEASE_WAIT);
  end

  assign tick_rise_c = tick_i & ~tick_q;

  // A press being reported this cycle outranks a coincident tick edge
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tick_q      <= 1'b0;
      press_o     <= 1'b0;
      key_level_o <= 1'b0;
      jmp_o       <= 1'b0;
      press_cnt_o <= '0;
    end else begin
      tick_q      <= tick_i;
      press_o     <= press_set_c;
      key_level_o <= level_next_c;
      jmp_o       <= press_set_c | (jmp_o & (press_o | ~tick_rise_c));
      if (press_set_c) begin
        press_cnt_o <= press_cnt_o + 8'(1);
      end
    end
  end

endmodule

// File: tb/tb_jump_key_conditioner.sv
// Directed self-checking bench for jump_key_conditioner (DEBOUNCE_CYCLES=4).
module tb_jump_key_conditioner;

  logic       clk = 1'b0;
  logic       rstn;
  logic       key, key_n, tick;
  logic       jmp, press, level;
  logic [7:0] cnt;
  logic       jmp_n, press_n, level_n;
  logic [7:0] cnt_n;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int pulses_n = 0;
  int exp_cnt  = 0;
  int first_at = 0;

  always #5 clk = ~clk;

  jump_key_conditioner #(.DEBOUNCE_CYCLES(4), .KEY_ACTIVE_HIGH(1'b1)) dut (
    .clk(clk), .rstn(rstn), .key_i(key), .tick_i(tick),
    .jmp_o(jmp), .press_o(press), .key_level_o(level), .press_cnt_o(cnt)
  );

  jump_key_conditioner #(.DEBOUNCE_CYCLES(4), .KEY_ACTIVE_HIGH(1'b0)) dut_n (
    .clk(clk), .rstn(rstn), .key_i(key_n), .tick_i(tick),
    .jmp_o(jmp_n), .press_o(press_n), .key_level_o(level_n), .press_cnt_o(cnt_n)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (press === 1'b1) pulses++;
      if (press_n === 1'b1) pulses_n++;
    end
  endtask

  task automatic press_release();
    key = 1'b1;
    step(8);
    key = 1'b0;
    step(8);
    exp_cnt++;
  endtask

  initial begin
    rstn = 1'b0; key = 1'b0; key_n = 1'b1; tick = 1'b0;
    step(3);
    check_eq("rst_press", 32'(press), 0);
    check_eq("rst_jmp", 32'(jmp), 0);
    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_cnt", 32'(cnt), 0);
    check_eq("rst_n_level", 32'(level_n), 0);
    check_eq("rst_n_press", 32'(press_n), 0);
    rstn = 1'b1;
    step(2);

    // Clean press: pulse on the 7th edge after the raw edge
    key = 1'b1;
    step(6);
    check_eq("clean_early", 32'(press), 0);
    step(1);
    check_eq("clean_press", 32'(press), 1);
    check_eq("clean_jmp", 32'(jmp), 1);
    check_eq("clean_level", 32'(level), 1);
    check_eq("clean_cnt", 32'(cnt), 1);
    pulses = 0;
    step(13);
    check_eq("clean_norepeat", 32'(pulses), 0);
    exp_cnt = 1;

    // Consume by tick rising edge; second edge keeps it clear
    check_eq("consume_pre", 32'(jmp), 1);
    tick = 1'b1; step(1);
    check_eq("consume", 32'(jmp), 0);
    tick = 1'b0; step(1);
    tick = 1'b1; step(1);
    check_eq("consume_second", 32'(jmp), 0);
    tick = 1'b0;
    key = 1'b0;
    step(8);
    check_eq("release_level", 32'(level), 0);

    // Bounce then hold
    pulses = 0;
    key = 1'b1; step(2);
    key = 1'b0; step(2);
    key = 1'b1; step(2);
    key = 1'b0; step(2);
    key = 1'b1;
    first_at = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (press === 1'b1 && first_at == 0) first_at = i;
    end
    check_eq("bounce_pulses", 32'(pulses), 1);
    check_eq("bounce_latency", 32'(first_at), 7);
    check_eq("bounce_cnt", 32'(cnt), 2);
    exp_cnt = 2;
    tick = 1'b1; step(1);
    tick = 1'b0; step(1);
    key = 1'b0; step(8);

    // Collision: press_o and tick_rise in the same cycle
    key = 1'b1;
    step(7);
    check_eq("coll_press", 32'(press), 1);
    tick = 1'b1; step(1);
    check_eq("coll_hold", 32'(jmp), 1);
    tick = 1'b0; step(1);
    tick = 1'b1; step(1);
    check_eq("coll_clear", 32'(jmp), 0);
    tick = 1'b0;
    exp_cnt = 3;

    // Presses while requested do not queue
    key = 1'b0; step(8);
    press_release();
    press_release();
    check_eq("noqueue_cnt", 32'(cnt), 32'(exp_cnt));
    check_eq("noqueue_jmp", 32'(jmp), 1);
    tick = 1'b1; step(1);
    check_eq("noqueue_clear", 32'(jmp), 0);
    tick = 1'b0; step(1);
    tick = 1'b1; step(1);
    check_eq("noqueue_second", 32'(jmp), 0);
    tick = 1'b0;

    // Counter wrap
    while (exp_cnt < 255) press_release();
    check_eq("cnt_255", 32'(cnt), 255);
    press_release();
    check_eq("cnt_wrap", 32'(cnt), 0);

    // Reset mid-debounce with a pending request
    key = 1'b1;
    step(3);
    check_eq("pre_rst_jmp", 32'(jmp), 1);
    rstn = 1'b0; step(1);
    check_eq("mid_rst_press", 32'(press), 0);
    check_eq("mid_rst_jmp", 32'(jmp), 0);
    check_eq("mid_rst_level", 32'(level), 0);
    check_eq("mid_rst_cnt", 32'(cnt), 0);
    rstn = 1'b1;
    pulses = 0;
    step(15);
    check_eq("held_rst_pulses", 32'(pulses), 1);
    check_eq("held_rst_cnt", 32'(cnt), 1);
    check_eq("held_rst_level", 32'(level), 1);

    // Active-low key variant
    pulses_n = 0;
    key_n = 1'b0; step(10);
    check_eq("pol_pulses", 32'(pulses_n), 1);
    check_eq("pol_level", 32'(level_n), 1);
    check_eq("pol_cnt", 32'(cnt_n), 1);
    key_n = 1'b1; step(5);
    check_eq("pol_level_hold", 32'(level_n), 1);
    step(3);
    check_eq("pol_level_rel", 32'(level_n), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
